// File: rtl/hdmi_stream_tx_if.sv
// rtl/hdmi_stream_tx_if.sv - Avalon-ST style pixel stream bundle feeding the raster converter
interface hdmi_stream_tx_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  startofpacket;
    logic                  endofpacket;

    modport master (output valid, data, startofpacket, endofpacket, input ready);
    modport slave  (input valid, data, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/hdmi_stream_tx.sv
// rtl/hdmi_stream_tx.sv - video timing generator and stream-to-raster converter with frame lock
module hdmi_stream_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 1280,
    parameter int H_FRONT    = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BACK     = 220,
    parameter int V_ACTIVE   = 720,
    parameter int V_FRONT    = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BACK     = 20,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int CNT_W      = 13
) (
    input  logic             clk,
    input  logic             reset,
    hdmi_stream_tx_if.slave  asi_snk,
    output logic             de_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic [7:0]       data_r_o,
    output logic [7:0]       data_g_o,
    output logic [7:0]       data_b_o,
    output logic             frame_start_o,
    output logic             underflow_o,
    output logic             resync_o
);
    localparam int HTOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int VTOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LASTP = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HTOTAL - 1);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_LASTP = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(VTOTAL - 1);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    localparam logic [1:0] S_SEEK = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [CNT_W-1:0]      r_h_cnt;
    logic [CNT_W-1:0]      r_v_cnt;
    logic [1:0]            r_state;
    logic                  r_uflow_seen;
    logic                  r_de;
    logic                  r_hs;
    logic                  r_vs;
    logic                  r_fs;
    logic                  r_uf;
    logic                  r_rs;
    logic [DATA_WIDTH-1:0] r_pix;

    logic w_active;
    logic w_h_wrap;
    logic w_wrap;
    logic w_first;
    logic w_last_pix;
    logic w_run_px;
    logic w_beat;
    logic w_err_sop0;
    logic w_err_midsop;
    logic w_err_eop;
    logic w_resync;
    logic w_good;
    logic w_uflow;
    logic w_ready;

    assign w_active   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_h_wrap   = (r_h_cnt == H_LAST);
    assign w_wrap     = w_h_wrap && (r_v_cnt == V_LAST);
    assign w_first    = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_last_pix = (r_h_cnt == H_LASTP) && (r_v_cnt == V_LASTP);

    // A mid-frame sop is left on the bus so it can start the next frame; eop is judged only on consumed beats
    assign w_run_px     = (r_state == S_RUN) && w_active;
    assign w_beat       = w_run_px && asi_snk.valid;
    assign w_err_sop0   = w_beat && w_first && !asi_snk.startofpacket;
    assign w_err_midsop = w_beat && !w_first && asi_snk.startofpacket;
    assign w_err_eop    = w_beat && !w_err_midsop && asi_snk.endofpacket && !w_last_pix;
    assign w_resync     = w_err_sop0 || w_err_midsop || w_err_eop;
    assign w_good       = w_beat && !w_resync;
    assign w_uflow      = w_run_px && !asi_snk.valid;

    always_comb begin
        w_ready = 1'b0;
        if (!reset) begin
            case (r_state)
                S_SEEK:  w_ready = !(asi_snk.valid && asi_snk.startofpacket);
                S_RUN:   w_ready = w_active && !w_err_midsop;
                default: w_ready = 1'b0;
            endcase
        end
    end
    assign asi_snk.ready = w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_SEEK;
            r_uflow_seen <= 1'b0;
        end else begin
            case (r_state)
                S_SEEK: if (asi_snk.valid && asi_snk.startofpacket) r_state <= S_WAIT;
                S_WAIT: if (w_wrap) r_state <= S_RUN;
                S_RUN: begin
                    if (w_err_midsop)
                        r_state <= S_WAIT;
                    else if (w_err_sop0 || w_err_eop)
                        r_state <= S_SEEK;
                    else if (w_wrap && (r_uflow_seen || w_uflow))
                        r_state <= S_SEEK;
                end
                default: r_state <= S_SEEK;
            endcase
            if (w_wrap || (r_state != S_RUN))
                r_uflow_seen <= 1'b0;
            else if (w_uflow)
                r_uflow_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_de  <= 1'b0;
            r_hs  <= !HS_POL;
            r_vs  <= !VS_POL;
            r_pix <= '0;
            r_fs  <= 1'b0;
            r_uf  <= 1'b0;
            r_rs  <= 1'b0;
        end else begin
            r_de  <= w_active;
            r_hs  <= ((r_h_cnt >= HS_BEG) && (r_h_cnt <= HS_END)) ? HS_POL : !HS_POL;
            r_vs  <= ((r_v_cnt >= VS_BEG) && (r_v_cnt <= VS_END)) ? VS_POL : !VS_POL;
            r_pix <= w_good ? asi_snk.data : '0;
            r_fs  <= w_good && w_first;
            r_uf  <= w_uflow;
            r_rs  <= w_resync;
        end
    end

    assign de_o          = r_de;
    assign hsync_o       = r_hs;
    assign vsync_o       = r_vs;
    assign data_r_o      = r_pix[23:16];
    assign data_g_o      = r_pix[15:8];
    assign data_b_o      = r_pix[7:0];
    assign frame_start_o = r_fs;
    assign underflow_o   = r_uf;
    assign resync_o      = r_rs;
endmodule

// File: tb/tb_hdmi_stream_tx.sv
// tb/tb_hdmi_stream_tx.sv - self-checking bench for hdmi_stream_tx on a 15x8 raster
module tb_hdmi_stream_tx;
    localparam int HT = 15;
    localparam int FR = 120;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       de, hs, vs, fs, uf, rs;
    logic [7:0] dr, dg, db;

    hdmi_stream_tx_if #(.DATA_WIDTH(24)) s_if ();

    hdmi_stream_tx #(
        .DATA_WIDTH(24), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .asi_snk(s_if),
        .de_o(de), .hsync_o(hs), .vsync_o(vs),
        .data_r_o(dr), .data_g_o(dg), .data_b_o(db),
        .frame_start_o(fs), .underflow_o(uf), .resync_o(rs)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [23:0] d; logic sop; logic eop; } beat_t;
    beat_t       q[$];
    logic [23:0] fd   [0:7][0:31];
    logic [29:0] obs  [0:1023];
    logic [29:0] expv [0:1023];
    logic        rdy  [0:1023];
    int          cyc, gap_cycle, n_cmp, n_fail;

    // Expected output vector for raster cycle k, from the timing rules alone
    function automatic logic [29:0] raster(int k, logic [23:0] d, bit f, bit u, bit r);
        int h = k % HT;
        int v = (k / HT) % 8;
        logic a  = (h < 8) && (v < 4);
        logic hz = (h >= 10) && (h <= 12);
        logic vz = (v == 5) || (v == 6);
        return {a, hz, vz, f, u, r, a ? d : 24'h0};
    endfunction

    function automatic int pk(int fr, int p);
        return fr * FR + (p / 8) * HT + (p % 8);
    endfunction

    task automatic new_frame(int f);
        for (int p = 0; p < 32; p++) fd[f][p] = {16'($urandom()), 8'(p)};
    endtask

    task automatic push_frame(int f, int n);
        beat_t b;
        for (int p = 0; p < n; p++) begin
            b.d = fd[f][p]; b.sop = (p == 0); b.eop = (p == 31);
            q.push_back(b);
        end
    endtask

    task automatic fill_black(int nk);
        for (int k = 0; k < nk; k++) expv[k] = raster(k, 24'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exp_frame(int fr, int f);
        for (int p = 0; p < 32; p++) expv[pk(fr, p)] = raster(pk(fr, p), fd[f][p], p == 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        s_if.valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        gap_cycle = -1;
        q.delete();
    endtask

    // Each iteration starts at a negedge: capture outputs of the previous raster cycle, then drive this one
    task automatic run(int n);
        logic [29:0] cur;
        for (int i = 0; i < n; i++) begin
            cur = {de, hs, vs, fs, uf, rs, dr, dg, db};
            if (cyc > 0 && cyc <= 1024) obs[cyc-1] = cur;
            if (q.size() > 0 && cyc != gap_cycle) begin
                s_if.valid = 1'b1; s_if.data = q[0].d;
                s_if.startofpacket = q[0].sop; s_if.endofpacket = q[0].eop;
            end else begin
                s_if.valid = 1'b0; s_if.data = 24'($urandom());
                s_if.startofpacket = 1'($urandom()); s_if.endofpacket = 1'b0;
            end
            #1;
            if (cyc < 1024) rdy[cyc] = s_if.ready;
            if (s_if.valid && s_if.ready) void'(q.pop_front());
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        s_if.valid = 1'b1; s_if.startofpacket = 1'b0; s_if.endofpacket = 1'b0; s_if.data = 24'hABCDEF;
        #1;
        n_cmp++;
        if (s_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b expected 0", s_if.ready); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({de, hs, vs, fs, uf, rs, dr, dg, db} !== 30'h0) begin
            n_fail++; $display("FAIL reset_outputs got %h expected 0", {de, hs, vs, fs, uf, rs, dr, dg, db});
        end
    endtask

    task automatic test_timing();
        int cnt;
        do_reset();
        run(241);
        fill_black(240);
        for (int k = 0; k < 240; k++) begin
            n_cmp++;
            if (obs[k] !== expv[k]) begin n_fail++; $display("FAIL timing k=%0d got %h expected %h", k, obs[k], expv[k]); end
        end
        for (int r = 0; r < 2; r++) begin
            cnt = 0;
            for (int k = r * FR; k < (r + 1) * FR; k++) cnt += int'(obs[k][29]);
            n_cmp++;
            if (cnt != 32) begin n_fail++; $display("FAIL de_count frame=%0d got %0d expected 32", r, cnt); end
        end
    endtask

    task automatic test_frames();
        int cnt;
        do_reset();
        for (int f = 0; f < 4; f++) begin new_frame(f); push_frame(f, 32); end
        run(601);
        fill_black(600);
        for (int r = 1; r <= 4; r++) exp_frame(r, r - 1);
        for (int k = 0; k < 600; k++) begin
            n_cmp++;
            if (obs[k] !== expv[k]) begin n_fail++; $display("FAIL frames k=%0d got %h expected %h", k, obs[k], expv[k]); end
        end
        for (int r = 0; r < 5; r++) begin
            cnt = 0;
            for (int k = r * FR; k < (r + 1) * FR; k++) cnt += int'(rdy[k]);
            n_cmp++;
            if (cnt != ((r == 0) ? 0 : 32)) begin
                n_fail++; $display("FAIL ready_count frame=%0d got %0d expected %0d", r, cnt, (r == 0) ? 0 : 32);
            end
        end
    endtask

    task automatic test_seek_drop();
        beat_t b;
        int    nj;
        do_reset();
        nj = int'($urandom_range(1, 8));
        for (int i = 0; i < nj; i++) begin
            b.d = 24'($urandom()); b.sop = 1'b0; b.eop = 1'($urandom());
            q.push_back(b);
        end
        new_frame(0); new_frame(1); push_frame(0, 32); push_frame(1, 32);
        run(361);
        fill_black(360);
        exp_frame(1, 0);
        exp_frame(2, 1);
        for (int k = 0; k < 360; k++) begin
            n_cmp++;
            if (obs[k] !== expv[k]) begin n_fail++; $display("FAIL seek k=%0d got %h expected %h", k, obs[k], expv[k]); end
        end
        for (int k = 0; k <= nj; k++) begin
            n_cmp++;
            if (rdy[k] !== (k < nj)) begin n_fail++; $display("FAIL seek_ready k=%0d got %b expected %b", k, rdy[k], k < nj); end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        for (int f = 0; f < 3; f++) begin new_frame(f); push_frame(f, 32); end
        gap_cycle = pk(1, 11);
        run(481);
        fill_black(480);
        for (int p = 0; p < 32; p++) begin
            if (p < 11)       expv[pk(1, p)] = raster(pk(1, p), fd[0][p], p == 0, 1'b0, 1'b0);
            else if (p == 11) expv[pk(1, p)] = raster(pk(1, p), 24'h0, 1'b0, 1'b1, 1'b0);
            else              expv[pk(1, p)] = raster(pk(1, p), fd[0][p-1], 1'b0, 1'b0, 1'b0);
        end
        exp_frame(3, 1);
        for (int k = 0; k < 480; k++) begin
            n_cmp++;
            if (obs[k] !== expv[k]) begin n_fail++; $display("FAIL underflow k=%0d got %h expected %h", k, obs[k], expv[k]); end
        end
        n_cmp++;
        if (rdy[240] !== 1'b1 || rdy[241] !== 1'b0) begin
            n_fail++; $display("FAIL underflow_seek_ready got %b%b expected 10", rdy[240], rdy[241]);
        end
    endtask

    task automatic test_resync();
        do_reset();
        for (int f = 0; f < 3; f++) new_frame(f);
        push_frame(0, 32); push_frame(1, 20); push_frame(2, 32);
        run(481);
        fill_black(480);
        exp_frame(1, 0);
        for (int p = 0; p < 20; p++) expv[pk(2, p)] = raster(pk(2, p), fd[1][p], p == 0, 1'b0, 1'b0);
        expv[pk(2, 20)] = raster(pk(2, 20), 24'h0, 1'b0, 1'b0, 1'b1);
        exp_frame(3, 2);
        for (int k = 0; k < 480; k++) begin
            n_cmp++;
            if (obs[k] !== expv[k]) begin n_fail++; $display("FAIL resync k=%0d got %h expected %h", k, obs[k], expv[k]); end
        end
        n_cmp++;
        if (rdy[pk(2, 20)] !== 1'b0) begin n_fail++; $display("FAIL resync_ready got %b expected 0", rdy[pk(2, 20)]); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        new_frame(0); new_frame(1); push_frame(0, 32); push_frame(1, 32);
        run(pk(1, 21));
        reset = 1'b1;
        #1;
        n_cmp++;
        if (s_if.ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready got %b expected 0", s_if.ready); end
        @(negedge clk);
        n_cmp++;
        if ({de, hs, vs, fs, uf, rs, dr, dg, db} !== 30'h0) begin
            n_fail++; $display("FAIL midreset_outputs got %h expected 0", {de, hs, vs, fs, uf, rs, dr, dg, db});
        end
        reset = 1'b0;
        cyc = 0;
        q.delete();
        new_frame(2); push_frame(2, 32);
        run(241);
        fill_black(240);
        exp_frame(1, 2);
        for (int k = 0; k < 240; k++) begin
            n_cmp++;
            if (obs[k] !== expv[k]) begin n_fail++; $display("FAIL midreset k=%0d got %h expected %h", k, obs[k], expv[k]); end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0; gap_cycle = -1;
        s_if.valid = 1'b0; s_if.data = 24'h0; s_if.startofpacket = 1'b0; s_if.endofpacket = 1'b0;
        test_reset();
        test_timing();
        test_frames();
        test_seek_drop();
        test_underflow();
        test_resync();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
